// File: rtl/timer_bank.sv
// Bank of N_CH independent down-counting timers behind one register port.
// Each channel has its own reload, prescale and mode, and raises a one-cycle interrupt on expiry.
module timer_bank #(
  parameter int N_CH             = 4,
  parameter int CNT_W            = 32,
  parameter int PRE_W            = 32,
  parameter int DEFAULT_PRESCALE = 99999,
  localparam int SEL_W           = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SEL_W-1:0]  chSel,
  input  logic [31:0]       wrData,
  input  logic              setValue,
  input  logic              setPrescale,
  input  logic              setMode,
  input  logic              trigger,
  input  logic              stop,
  output logic [N_CH-1:0]   interrupt,
  output logic [N_CH-1:0]   running,
  output logic [CNT_W-1:0]  rdCount
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_q   [N_CH];
  state_t           state_d   [N_CH];
  logic [CNT_W-1:0] reload_q  [N_CH];
  logic [CNT_W-1:0] reload_d  [N_CH];
  logic [PRE_W-1:0] prescale_q[N_CH];
  logic [PRE_W-1:0] prescale_d[N_CH];
  logic [PRE_W-1:0] act_pre_q [N_CH];
  logic [PRE_W-1:0] act_pre_d [N_CH];
  logic [CNT_W-1:0] count_q   [N_CH];
  logic [CNT_W-1:0] count_d   [N_CH];
  logic [PRE_W-1:0] tick_q    [N_CH];
  logic [PRE_W-1:0] tick_d    [N_CH];
  logic [N_CH-1:0]  periodic_q;
  logic [N_CH-1:0]  periodic_d;
  logic [N_CH-1:0]  interrupt_q;
  logic [N_CH-1:0]  interrupt_d;
  logic [N_CH-1:0]  running_q;
  logic [N_CH-1:0]  running_d;
  logic [N_CH-1:0]  hit_s;
  logic [CNT_W-1:0] rd_count_s;

  // Channel decode and live-count read mux.
  always_comb begin
    rd_count_s = {CNT_W{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      hit_s[i]   = (chSel == SEL_W'(i));
      rd_count_s = rd_count_s | ({CNT_W{hit_s[i]}} & count_q[i]);
    end
  end

  // Config writes and per-channel IDLE/RUN next-state logic.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      reload_d[i]    = (hit_s[i] && setValue)    ? CNT_W'(wrData) : reload_q[i];
      prescale_d[i]  = (hit_s[i] && setPrescale) ? PRE_W'(wrData) : prescale_q[i];
      periodic_d[i]  = (hit_s[i] && setMode)     ? wrData[0]      : periodic_q[i];
      state_d[i]     = state_q[i];
      count_d[i]     = count_q[i];
      tick_d[i]      = tick_q[i];
      act_pre_d[i]   = act_pre_q[i];
      interrupt_d[i] = 1'b0;
      // A trigger sees the config value written in the same cycle; a periodic
      // reload uses the stored config. The active prescale is latched at start so
      // mid-run prescale writes do not disturb the running period.
      case (state_q[i])
        ST_IDLE: begin
          if (hit_s[i] && trigger) begin
            state_d[i]   = ST_RUN;
            count_d[i]   = reload_d[i];
            tick_d[i]    = prescale_d[i];
            act_pre_d[i] = prescale_d[i];
          end else begin
            state_d[i] = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (hit_s[i] && stop) begin
            state_d[i] = ST_IDLE;
          end else if (hit_s[i] && trigger) begin
            count_d[i]   = reload_d[i];
            tick_d[i]    = prescale_d[i];
            act_pre_d[i] = prescale_d[i];
          end else if (count_q[i] == {CNT_W{1'b0}}) begin
            interrupt_d[i] = 1'b1;
            if (periodic_q[i]) begin
              count_d[i]   = reload_q[i];
              tick_d[i]    = prescale_q[i];
              act_pre_d[i] = prescale_q[i];
            end else begin
              state_d[i] = ST_IDLE;
            end
          end else if (tick_q[i] == {PRE_W{1'b0}}) begin
            count_d[i] = count_q[i] - CNT_W'(1);
            tick_d[i]  = act_pre_q[i];
          end else begin
            tick_d[i] = tick_q[i] - PRE_W'(1);
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
        end
      endcase
      running_d[i] = (state_d[i] == ST_RUN);
    end
  end

  // State and configuration registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i]    <= ST_IDLE;
        reload_q[i]   <= {CNT_W{1'b0}};
        prescale_q[i] <= PRE_W'(DEFAULT_PRESCALE);
        act_pre_q[i]  <= PRE_W'(DEFAULT_PRESCALE);
        count_q[i]    <= {CNT_W{1'b0}};
        tick_q[i]     <= {PRE_W{1'b0}};
      end
      periodic_q  <= {N_CH{1'b0}};
      interrupt_q <= {N_CH{1'b0}};
      running_q   <= {N_CH{1'b0}};
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i]    <= state_d[i];
        reload_q[i]   <= reload_d[i];
        prescale_q[i] <= prescale_d[i];
        act_pre_q[i]  <= act_pre_d[i];
        count_q[i]    <= count_d[i];
        tick_q[i]     <= tick_d[i];
      end
      periodic_q  <= periodic_d;
      interrupt_q <= interrupt_d;
      running_q   <= running_d;
    end
  end

  assign interrupt = interrupt_q;
  assign running   = running_q;
  assign rdCount   = rd_count_s;

endmodule

// File: tb/tb_timer_bank.sv
// Self-checking bench for timer_bank: directed vector table, multi-cycle
// corner sequences and randomized traffic against an elapsed-time reference model.
module tb_timer_bank;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  chSel;
  logic [31:0] wrData;
  logic        setValue, setPrescale, setMode, trigger, stop;
  logic [3:0]  interrupt, running;
  logic [31:0] rdCount;

  always #5 clk = ~clk;

  timer_bank #(.N_CH(4), .CNT_W(32), .PRE_W(32), .DEFAULT_PRESCALE(99999)) dut (
    .clk(clk), .reset(reset), .chSel(chSel), .wrData(wrData),
    .setValue(setValue), .setPrescale(setPrescale), .setMode(setMode),
    .trigger(trigger), .stop(stop),
    .interrupt(interrupt), .running(running), .rdCount(rdCount)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: a running channel is described by its start edge and the
  // reload/prescale captured at start; count and expiry follow from elapsed edges.
  longint cyc = 0;
  longint m_reload[N], m_pre[N], m_sr[N], m_sp[N], m_start[N], m_cnt[N];
  bit     m_per[N], m_run[N], m_irq[N];

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic start_ch(input int i, input longint r, input longint p);
    m_run[i] = 1'b1; m_start[i] = cyc; m_sr[i] = r; m_sp[i] = p; m_cnt[i] = r;
  endtask

  task automatic model_step();
    longint nr, np, e;
    bit nm, hit;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (reset) begin
        m_reload[i] = 0; m_pre[i] = 99999; m_per[i] = 1'b0;
        m_run[i] = 1'b0; m_cnt[i] = 0; m_irq[i] = 1'b0;
      end else begin
        hit = (int'(chSel) == i);
        nr = (hit && setValue)    ? longint'(wrData) : m_reload[i];
        np = (hit && setPrescale) ? longint'(wrData) : m_pre[i];
        nm = (hit && setMode)     ? wrData[0]        : m_per[i];
        m_irq[i] = 1'b0;
        if (!m_run[i]) begin
          if (hit && trigger) start_ch(i, nr, np);
        end else if (hit && stop) begin
          m_run[i] = 1'b0;
        end else if (hit && trigger) begin
          start_ch(i, nr, np);
        end else begin
          e = cyc - m_start[i];
          if (e == m_sr[i] * (m_sp[i] + 1) + 1) begin
            m_irq[i] = 1'b1;
            if (m_per[i]) start_ch(i, m_reload[i], m_pre[i]);
            else begin m_run[i] = 1'b0; m_cnt[i] = 0; end
          end else begin
            m_cnt[i] = m_sr[i] - e / (m_sp[i] + 1);
          end
        end
        m_reload[i] = nr; m_pre[i] = np; m_per[i] = nm;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic r, input int sel, input logic [31:0] wr,
                       input logic sv, input logic sp, input logic sm,
                       input logic tg, input logic st);
    reset = r; chSel = 2'(sel); wrData = wr;
    setValue = sv; setPrescale = sp; setMode = sm; trigger = tg; stop = st;
  endtask

  task automatic check_model(input string tag);
    logic [3:0] ei, er;
    for (int i = 0; i < N; i++) begin
      ei[i] = m_irq[i];
      er[i] = m_run[i];
    end
    chk({tag, " irq"}, interrupt, ei);
    chk({tag, " run"}, running, er);
    chk({tag, " cnt"}, rdCount, m_cnt[int'(chSel)]);
  endtask

  typedef struct {
    logic        rst;
    int          sel;
    logic [31:0] wr;
    logic        sv, sp, sm, tg, st;
    logic [3:0]  e_irq, e_run;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic rst, input int sel, input logic [31:0] wr,
                              input logic sv, input logic sp, input logic sm,
                              input logic tg, input logic st,
                              input logic [3:0] e_irq, input logic [3:0] e_run,
                              input logic [31:0] e_cnt);
    vec_t v;
    v.rst = rst; v.sel = sel; v.wr = wr; v.sv = sv; v.sp = sp; v.sm = sm;
    v.tg = tg; v.st = st; v.e_irq = e_irq; v.e_run = e_run; v.e_cnt = e_cnt;
    tbl.push_back(v);
  endfunction

  initial begin
    int first, npulse, fall;
    longint t0;
    int pulses[$];
    logic [3:0] seen;

    // Reset readback on every channel.
    for (int s = 0; s < 4; s++) add(1'b1, s, 32'd0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 32'd0);
    // ch2 reload 0: interrupt after edge 1.
    add(1'b0, 2, 32'd0, 0, 0, 0, 1, 0, 4'h0, 4'h4, 32'd0);
    add(1'b0, 2, 32'd0, 0, 0, 0, 0, 0, 4'h4, 4'h0, 32'd0);
    add(1'b0, 2, 32'd0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 32'd0);
    // ch3 prescale 0, trigger with write-through reload 4: interrupt after edge 5.
    add(1'b0, 3, 32'd0, 0, 1, 0, 0, 0, 4'h0, 4'h0, 32'd0);
    add(1'b0, 3, 32'd4, 1, 0, 0, 1, 0, 4'h0, 4'h8, 32'd4);
    for (int k = 1; k <= 4; k++) add(1'b0, 3, 32'd0, 0, 0, 0, 0, 0, 4'h0, 4'h8, 32'(4 - k));
    add(1'b0, 3, 32'd0, 0, 0, 0, 0, 0, 4'h8, 4'h0, 32'd0);
    add(1'b0, 3, 32'd0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 32'd0);
    // ch0 reload 10 prescale 0, retrigger at edge 6: interrupt after edge 17.
    add(1'b0, 0, 32'd0,  0, 1, 0, 0, 0, 4'h0, 4'h0, 32'd0);
    add(1'b0, 0, 32'd10, 1, 0, 0, 0, 0, 4'h0, 4'h0, 32'd0);
    add(1'b0, 0, 32'd0,  0, 0, 0, 1, 0, 4'h0, 4'h1, 32'd10);
    for (int k = 1; k <= 5; k++) add(1'b0, 0, 32'd0, 0, 0, 0, 0, 0, 4'h0, 4'h1, 32'(10 - k));
    add(1'b0, 0, 32'd0, 0, 0, 0, 1, 0, 4'h0, 4'h1, 32'd10);
    for (int k = 1; k <= 10; k++) add(1'b0, 0, 32'd0, 0, 0, 0, 0, 0, 4'h0, 4'h1, 32'(10 - k));
    add(1'b0, 0, 32'd0, 0, 0, 0, 0, 0, 4'h1, 4'h0, 32'd0);
    add(1'b0, 0, 32'd0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 32'd0);

    drive(1'b1, 0, 32'd0, 0, 0, 0, 0, 0);
    step(); step();

    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k].rst, tbl[k].sel, tbl[k].wr, tbl[k].sv, tbl[k].sp, tbl[k].sm, tbl[k].tg, tbl[k].st);
      step();
      chk($sformatf("vec%0d irq", k), interrupt, tbl[k].e_irq);
      chk($sformatf("vec%0d run", k), running,   tbl[k].e_run);
      chk($sformatf("vec%0d cnt", k), rdCount,   tbl[k].e_cnt);
    end

    // ch0 one-shot, prescale 3, reload 5: single pulse after edge 21.
    drive(1'b0, 0, 32'd3, 0, 1, 0, 0, 0); step();
    drive(1'b0, 0, 32'd5, 1, 0, 0, 0, 0); step();
    drive(1'b0, 0, 32'd0, 0, 0, 1, 0, 0); step();
    drive(1'b0, 0, 32'd0, 0, 0, 0, 1, 0); step();
    t0 = cyc; first = -1; npulse = 0; fall = -1;
    drive(1'b0, 0, 32'd0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 120; k++) begin
      step();
      if (interrupt[0]) begin
        npulse++;
        if (first < 0) first = int'(cyc - t0);
      end
      if (!running[0] && fall < 0) fall = int'(cyc - t0);
    end
    chk("oneshot first pulse edge", first, 21);
    chk("oneshot pulse count", npulse, 1);
    chk("oneshot running fall edge", fall, 21);

    // ch1 periodic, prescale 1, reload 2: pulses every 5 cycles, then stop.
    drive(1'b0, 1, 32'd1, 0, 1, 0, 0, 0); step();
    drive(1'b0, 1, 32'd2, 1, 0, 0, 0, 0); step();
    drive(1'b0, 1, 32'd1, 0, 0, 1, 0, 0); step();
    drive(1'b0, 1, 32'd0, 0, 0, 0, 1, 0); step();
    t0 = cyc;
    drive(1'b0, 1, 32'd0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 16; k++) begin
      step();
      if (interrupt[1]) pulses.push_back(int'(cyc - t0));
    end
    chk("periodic pulse count", pulses.size(), 3);
    for (int k = 0; k < pulses.size(); k++) chk($sformatf("periodic pulse%0d edge", k), pulses[k], 5 * (k + 1));
    drive(1'b0, 1, 32'd0, 0, 0, 0, 0, 1); step();
    chk("stop running", running[1], 0);
    drive(1'b0, 1, 32'd0, 0, 0, 0, 0, 0);
    npulse = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (interrupt[1]) npulse++;
    end
    chk("stopped pulses", npulse, 0);
    chk("stopped count frozen", rdCount, 2);

    // stop together with trigger on a running channel goes to IDLE.
    drive(1'b0, 0, 32'd0,  0, 1, 0, 0, 0); step();
    drive(1'b0, 0, 32'd10, 1, 0, 0, 1, 0); step();
    drive(1'b0, 0, 32'd0,  0, 0, 0, 0, 0); step(); step();
    drive(1'b0, 0, 32'd0,  0, 0, 0, 1, 1); step();
    chk("stop+trigger running", running[0], 0);
    chk("stop+trigger count kept", rdCount, 8);

    // All channels running, reset mid-run.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, i, 32'd1, 0, 1, 0, 0, 0); step();
      drive(1'b0, i, 32'(3 + i), 1, 0, 0, 0, 0); step();
      drive(1'b0, i, 32'd1, 0, 0, 1, 0, 0); step();
      drive(1'b0, i, 32'd0, 0, 0, 0, 1, 0); step();
    end
    drive(1'b0, 0, 32'd0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) step();
    chk("prereset running", running, 4'hf);
    drive(1'b1, 0, 32'd0, 0, 0, 0, 0, 0); step();
    chk("reset irq", interrupt, 0);
    chk("reset running", running, 0);
    for (int s = 0; s < 4; s++) begin
      chSel = 2'(s);
      #1;
      chk($sformatf("reset cnt ch%0d", s), rdCount, 0);
    end
    drive(1'b0, 0, 32'd0, 0, 0, 0, 0, 0);
    seen = 4'h0;
    for (int k = 0; k < 60; k++) begin
      step();
      seen = seen | interrupt;
    end
    chk("post-reset irq", seen, 0);
    chk("post-reset running", running, 0);

    // Randomized traffic against the reference model.
    for (int k = 0; k < 3000; k++) begin
      drive(($urandom_range(0, 299) == 0), int'($urandom_range(0, 3)), 32'($urandom_range(0, 5)),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0));
      step();
      check_model($sformatf("rnd%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
